// File: rtl/str_to_ram_pkg.sv
// Shared types for the stream-to-RAM acquisition sequencer: FSM states and
// the control-command priority ordering.
package str_to_ram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Control commands in priority order, highest first (rst sits above all).
    typedef enum logic [2:0] {
        CMD_RST  = 3'd0,
        CMD_STOP = 3'd1,
        CMD_ARM  = 3'd2,
        CMD_TRG  = 3'd3,
        CMD_NONE = 3'd4
    } cmd_t;

    function automatic cmd_t pick_cmd(input logic rst_req, input logic stop_req,
                                      input logic arm_req, input logic trg_req);
        if (rst_req)       return CMD_RST;
        else if (stop_req) return CMD_STOP;
        else if (arm_req)  return CMD_ARM;
        else if (trg_req)  return CMD_TRG;
        else               return CMD_NONE;
    endfunction

endpackage

// File: rtl/str_to_ram_ctl.sv
// Acquisition sequencer: writes a sample stream into a circular RAM buffer
// through arm / pre-fill / armed / post-count / done, exporting status.
module str_to_ram_ctl
    import str_to_ram_pkg::*;
#(
    parameter int AW = 14,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_rst,
    input  logic          ctl_arm,
    input  logic          ctl_stop,
    input  logic          ctl_trg,
    input  logic          ext_trg,
    input  logic [CW-1:0] cfg_pre,
    input  logic [CW-1:0] cfg_pst,
    input  logic          str_tvalid,
    output logic          str_tready,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic          sts_run,
    output logic          sts_trg,
    output logic          sts_done,
    output logic [AW-1:0] sts_ptr,
    output logic [CW-1:0] sts_pre,
    output logic [CW-1:0] sts_pst
);

    state_t        state;
    cmd_t          cmd;
    logic [AW-1:0] wptr;
    logic          rdy;
    logic          trg;
    logic          xfer;
    logic          run;
    logic [CW-1:0] pre_nxt;
    logic [CW-1:0] pre_sat;
    logic [CW-1:0] pst_nxt;

    assign trg        = ctl_trg | ext_trg;
    assign str_tready = rdy;
    assign xfer       = str_tvalid & rdy;
    assign run        = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);
    assign sts_run    = run;
    assign sts_done   = (state == ST_DONE);
    assign ram_we     = xfer & run;
    assign ram_wa     = wptr;

    assign pre_nxt = sts_pre + CW'(1);
    assign pre_sat = (sts_pre == '1) ? sts_pre : pre_nxt;
    assign pst_nxt = sts_pst + CW'(1);

    // Stop only counts as a command while running, so arm still works from IDLE/DONE.
    assign cmd = pick_cmd(ctl_rst, ctl_stop & run, ctl_arm, trg);

    // NOTE: sequential state uses non-blocking assignments so every branch below
    // reads the pre-edge values, and later assignments override earlier ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            wptr    <= '0;
            sts_ptr <= '0;
            sts_pre <= '0;
            sts_pst <= '0;
            sts_trg <= 1'b0;
            rdy     <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (ram_we) wptr <= wptr + AW'(1);

            case (cmd)
                CMD_RST: begin
                    state   <= ST_IDLE;
                    wptr    <= '0;
                    sts_ptr <= '0;
                    sts_pre <= '0;
                    sts_pst <= '0;
                    sts_trg <= 1'b0;
                end
                CMD_STOP: state <= ST_DONE;
                CMD_ARM: begin
                    state   <= (cfg_pre == '0) ? ST_ARMED : ST_PRE;
                    wptr    <= '0;
                    sts_pre <= '0;
                    sts_pst <= '0;
                    sts_trg <= 1'b0;
                end
                default: begin
                    case (state)
                        ST_PRE: begin
                            if (ram_we) begin
                                sts_pre <= pre_nxt;
                                if (pre_nxt == cfg_pre) state <= ST_ARMED;
                            end
                        end
                        ST_ARMED: begin
                            if (trg) begin
                                sts_ptr <= wptr;
                                sts_trg <= 1'b1;
                                if (cfg_pst == '0) begin
                                    // Trigger-cycle sample stays on the pre-trigger side.
                                    state <= ST_DONE;
                                    if (ram_we) sts_pre <= pre_sat;
                                end else if (ram_we) begin
                                    sts_pst <= CW'(1);
                                    state   <= (cfg_pst == CW'(1)) ? ST_DONE : ST_POST;
                                end else begin
                                    state <= ST_POST;
                                end
                            end else if (ram_we) begin
                                sts_pre <= pre_sat;
                            end
                        end
                        ST_POST: begin
                            if (ram_we) begin
                                sts_pst <= pst_nxt;
                                if (pst_nxt == cfg_pst) state <= ST_DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_str_to_ram_ctl.sv
// Directed self-checking bench for str_to_ram_ctl with a 16-entry buffer.
module tb_str_to_ram_ctl;

    localparam int AW = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctl_rst, ctl_arm, ctl_stop, ctl_trg, ext_trg;
    logic [CW-1:0] cfg_pre, cfg_pst;
    logic          str_tvalid;
    logic          str_tready;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic          sts_run, sts_trg, sts_done;
    logic [AW-1:0] sts_ptr;
    logic [CW-1:0] sts_pre, sts_pst;

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] wr_q[$];

    str_to_ram_ctl #(.AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .ctl_rst(ctl_rst), .ctl_arm(ctl_arm),
        .ctl_stop(ctl_stop), .ctl_trg(ctl_trg), .ext_trg(ext_trg),
        .cfg_pre(cfg_pre), .cfg_pst(cfg_pst), .str_tvalid(str_tvalid),
        .str_tready(str_tready), .ram_we(ram_we), .ram_wa(ram_wa),
        .sts_run(sts_run), .sts_trg(sts_trg), .sts_done(sts_done),
        .sts_ptr(sts_ptr), .sts_pre(sts_pre), .sts_pst(sts_pst)
    );

    always #5 clk = ~clk;

    // Record every write address, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_we === 1'b1) wr_q.push_back(ram_wa);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ctl_rst = 0; ctl_arm = 0; ctl_stop = 0; ctl_trg = 0; ext_trg = 0;
        cfg_pre = '0; cfg_pst = '0; str_tvalid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_tready", str_tready, 1);
        check("rst_run", sts_run, 0);
        check("rst_done", sts_done, 0);
        check("rst_wa", ram_wa, 0);
        check("rst_ptr", sts_ptr, 0);
        check("rst_pre", sts_pre, 0);
        check("rst_pst", sts_pst, 0);
        check("rst_trg", sts_trg, 0);
        str_tvalid = 1'b1;
        #1;
        check("idle_we", ram_we, 0);

        // Basic capture: pre=4, pst=3, trigger two cycles after ARMED
        cfg_pre = 4; cfg_pst = 3;
        wr_q.delete();
        ctl_arm = 1; tick(); ctl_arm = 0;
        check("b_run", sts_run, 1);
        check("b_pre0", sts_pre, 0);
        repeat (4) tick();
        check("b_pre4", sts_pre, 4);
        repeat (2) tick();
        ctl_trg = 1; tick(); ctl_trg = 0;
        check("b_trg", sts_trg, 1);
        check("b_ptr", sts_ptr, 6);
        check("b_pst1", sts_pst, 1);
        check("b_pre6", sts_pre, 6);
        repeat (2) tick();
        check("b_done", sts_done, 1);
        check("b_run_off", sts_run, 0);
        check("b_pst3", sts_pst, 3);
        check("b_wa", ram_wa, 9);
        #1;
        check("b_we_off", ram_we, 0);
        check("b_nwr", wr_q.size(), 9);
        for (int i = 0; i < 9; i++) check("b_addr", wr_q[i], i);

        // Wrap with ignored triggers in PRE and POST
        cfg_pre = 20; cfg_pst = 5;
        wr_q.delete();
        ctl_arm = 1; tick(); ctl_arm = 0;
        check("w_wa0", ram_wa, 0);
        check("w_trg_clr", sts_trg, 0);
        check("w_ptr_held", sts_ptr, 6);
        repeat (4) tick();
        ctl_trg = 1; tick(); ctl_trg = 0;
        check("w_pre_trg_ign", sts_trg, 0);
        check("w_pre5", sts_pre, 5);
        repeat (16) tick();
        ext_trg = 1; tick(); ext_trg = 0;
        check("w_ptr", sts_ptr, 5);
        check("w_pst1", sts_pst, 1);
        check("w_pre21", sts_pre, 21);
        check("w_trg", sts_trg, 1);
        ctl_trg = 1; tick(); ctl_trg = 0;
        check("w_post_trg_ign", sts_ptr, 5);
        check("w_pst2", sts_pst, 2);
        repeat (3) tick();
        check("w_done", sts_done, 1);
        check("w_pst5", sts_pst, 5);
        check("w_wa", ram_wa, 10);
        check("w_nwr", wr_q.size(), 26);
        check("w_addr15", wr_q[15], 15);
        check("w_addr16", wr_q[16], 0);

        // Gapped stream: pre=2, pst=2, valid alternating
        cfg_pre = 2; cfg_pst = 2;
        str_tvalid = 0;
        wr_q.delete();
        ctl_arm = 1; tick(); ctl_arm = 0;
        str_tvalid = 1; #1;
        check("g_we_on", ram_we, 1);
        tick();
        check("g_pre1", sts_pre, 1);
        str_tvalid = 0; #1;
        check("g_we_gap", ram_we, 0);
        tick();
        check("g_pre_hold", sts_pre, 1);
        str_tvalid = 1; tick();
        check("g_pre2", sts_pre, 2);
        str_tvalid = 0; tick();
        check("g_pst0", sts_pst, 0);
        str_tvalid = 1; ctl_trg = 1; tick(); ctl_trg = 0; str_tvalid = 0;
        check("g_ptr", sts_ptr, 2);
        check("g_pst1", sts_pst, 1);
        tick();
        check("g_pst_hold", sts_pst, 1);
        check("g_run", sts_run, 1);
        str_tvalid = 1; tick();
        check("g_done", sts_done, 1);
        check("g_pst2", sts_pst, 2);
        check("g_wa", ram_wa, 4);
        check("g_nwr", wr_q.size(), 4);
        check("g_addr3", wr_q[3], 3);

        // cfg_pre=0 arms directly; stop+arm in POST ends in DONE
        cfg_pre = 0; cfg_pst = 10;
        ctl_arm = 1; tick(); ctl_arm = 0;
        check("s_run", sts_run, 1);
        check("s_pre0", sts_pre, 0);
        tick();
        ctl_trg = 1; tick(); ctl_trg = 0;
        check("s_trg", sts_trg, 1);
        check("s_ptr", sts_ptr, 1);
        tick();
        ctl_stop = 1; ctl_arm = 1; tick(); ctl_stop = 0; ctl_arm = 0;
        check("s_done", sts_done, 1);
        check("s_trg_kept", sts_trg, 1);
        check("s_pst", sts_pst, 2);
        check("s_pre", sts_pre, 1);
        check("s_wa", ram_wa, 4);

        // cfg_pst=0: DONE one cycle after trigger, trigger sample is pre-trigger
        cfg_pre = 1; cfg_pst = 0;
        ctl_arm = 1; tick(); ctl_arm = 0;
        tick();
        ctl_trg = 1; tick(); ctl_trg = 0;
        check("z_done", sts_done, 1);
        check("z_pst", sts_pst, 0);
        check("z_pre", sts_pre, 2);
        check("z_ptr", sts_ptr, 1);
        check("z_wa", ram_wa, 2);

        // ctl_rst in DONE
        ctl_rst = 1; tick(); ctl_rst = 0;
        check("c_done", sts_done, 0);
        check("c_run", sts_run, 0);
        check("c_ptr", sts_ptr, 0);
        check("c_pre", sts_pre, 0);
        check("c_pst", sts_pst, 0);
        check("c_trg", sts_trg, 0);
        check("c_wa", ram_wa, 0);

        // Stop in IDLE has no effect
        ctl_stop = 1; tick(); ctl_stop = 0;
        check("i_stop_ign", sts_done, 0);

        // Arm and trigger together from IDLE: arm wins; then async reset mid-POST
        cfg_pre = 1; cfg_pst = 8;
        ctl_arm = 1; ctl_trg = 1; tick(); ctl_arm = 0; ctl_trg = 0;
        check("a_trg_ign", sts_trg, 0);
        check("a_run", sts_run, 1);
        tick();
        ctl_trg = 1; tick(); ctl_trg = 0;
        check("a_pst1", sts_pst, 1);
        check("a_trg", sts_trg, 1);
        tick();
        check("a_pst2", sts_pst, 2);
        #3;
        rst = 1'b1;
        #1;
        check("ar_run", sts_run, 0);
        check("ar_done", sts_done, 0);
        check("ar_we", ram_we, 0);
        check("ar_wa", ram_wa, 0);
        check("ar_ptr", sts_ptr, 0);
        check("ar_pre", sts_pre, 0);
        check("ar_pst", sts_pst, 0);
        check("ar_trg", sts_trg, 0);
        #3;
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
